load_use_hazard_unit: RTL and testbench

//  Parametrised load-use hazard detector for the 5-stage MIPS pipeline; successor to the single-cycle lw interlock.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_tag_cmp.sv | 22 ++
 rtl/load_use_hazard_unit.sv | 125 ++++++++++++
 tb/tb_load_use_hazard_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard detector.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned MAX_LOAD_LAT = 4;

    localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] tag;
    } trk_entry_t;

endpackage

// File: rtl/hazard_tag_cmp.sv
// Compares one pending load destination against the real source operands of the ID instruction.
module hazard_tag_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              valid_i,
    input  logic [REG_AW-1:0] tag_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_use_i,
    input  logic              id_rt_use_i,
    output logic              hit_o
);

    logic match;

    assign match = (id_rs_use_i && (id_rs_i == tag_i)) || (id_rt_use_i && (id_rt_i == tag_i));
    // Register 0 is hard-wired zero, so a load into it never produces a dependency.
    assign hit_o = valid_i && (tag_i != REG_AW'(REG_ZERO)) && match;

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use interlock with a LOAD_LAT-1 stage tracker for multi-cycle data memory.
// Optional stall statistics counter enabled by defining HAZ_STALL_STATS_EN.
module load_use_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_use_i,
    input  logic              id_rt_use_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_memr_i,
    input  logic              ex_valid_i,
    input  logic              mem_wait_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              id_ex_bubble_o,
    output logic [15:0]       stall_cnt_o
);

    localparam int unsigned NumStages = LOAD_LAT - 1;

    logic ex_load;
    logic ex_hit;
    logic trk_hit;
    logic stall;

    assign ex_load = ex_valid_i & ex_memr_i;

    hazard_tag_cmp #(
        .REG_AW(REG_AW)
    ) u_ex_cmp (
        .valid_i    (ex_load),
        .tag_i      (ex_rd_i),
        .id_rs_i    (id_rs_i),
        .id_rt_i    (id_rt_i),
        .id_rs_use_i(id_rs_use_i),
        .id_rt_use_i(id_rt_use_i),
        .hit_o      (ex_hit)
    );

    generate
        if (NumStages > 0) begin : g_trk
            trk_entry_t           trk_q [NumStages];
            trk_entry_t           trk_d [NumStages];
            logic [NumStages-1:0] stage_hit;

            // A flushed EX load is squashed and never becomes pending.
            always_comb begin
                trk_d[0].valid = ex_load & ~flush_i;
                trk_d[0].tag   = ex_rd_i;
                for (int k = 1; k < NumStages; k++) begin
                    trk_d[k] = trk_q[k-1];
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int k = 0; k < NumStages; k++) begin
                        trk_q[k] <= '0;
                    end
                end else if (!mem_wait_i) begin
                    for (int k = 0; k < NumStages; k++) begin
                        trk_q[k] <= trk_d[k];
                    end
                end
            end

            for (genvar k = 0; k < NumStages; k++) begin : g_cmp
                hazard_tag_cmp #(
                    .REG_AW(REG_AW)
                ) u_trk_cmp (
                    .valid_i    (trk_q[k].valid),
                    .tag_i      (trk_q[k].tag),
                    .id_rs_i    (id_rs_i),
                    .id_rt_i    (id_rt_i),
                    .id_rs_use_i(id_rs_use_i),
                    .id_rt_use_i(id_rt_use_i),
                    .hit_o      (stage_hit[k])
                );
            end

            assign trk_hit = |stage_hit;
        end else begin : g_no_trk
            assign trk_hit = 1'b0;
        end
    endgenerate

    // A memory freeze already holds ID in place, so no separate stall is raised.
    assign stall          = (ex_hit | trk_hit) & ~flush_i & ~mem_wait_i;
    assign stall_o        = stall;
    assign pc_write_o     = ~stall & ~mem_wait_i;
    assign if_id_write_o  = ~stall & ~mem_wait_i;
    assign id_ex_bubble_o = (stall | flush_i) & ~mem_wait_i;

`ifdef HAZ_STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench: one hazard unit per LOAD_LAT (1..4) driven by shared stimulus.
module tb_load_use_hazard_unit;

`ifdef HAZ_STALL_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_rs_use, id_rt_use, ex_memr, ex_valid, mem_wait, flush;

    logic [4:1] stall, pcw, ifw, bub;
    logic [15:0] cnt [1:4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        load_use_hazard_unit #(
            .REG_AW  (5),
            .LOAD_LAT(g)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst_n),
            .id_rs_i       (id_rs),
            .id_rt_i       (id_rt),
            .id_rs_use_i   (id_rs_use),
            .id_rt_use_i   (id_rt_use),
            .ex_rd_i       (ex_rd),
            .ex_memr_i     (ex_memr),
            .ex_valid_i    (ex_valid),
            .mem_wait_i    (mem_wait),
            .flush_i       (flush),
            .stall_o       (stall[g]),
            .pc_write_o    (pcw[g]),
            .if_id_write_o (ifw[g]),
            .id_ex_bubble_o(bub[g]),
            .stall_cnt_o   (cnt[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic em, input logic [4:0] rd,
                         input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu, input logic fl, input logic mw);
        ex_valid  = ev;
        ex_memr   = em;
        ex_rd     = rd;
        id_rs     = rs;
        id_rs_use = rsu;
        id_rt     = rt;
        id_rt_use = rtu;
        flush     = fl;
        mem_wait  = mw;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #2;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("rst_stall_l%0d", i), 32'(stall[i]), 32'd0);
            check($sformatf("rst_pcw_l%0d", i), 32'(pcw[i]), 32'd1);
            check($sformatf("rst_ifw_l%0d", i), 32'(ifw[i]), 32'd1);
            check($sformatf("rst_bub_l%0d", i), 32'(bub[i]), 32'd0);
            check($sformatf("rst_cnt_l%0d", i), 32'(cnt[i]), 32'd0);
        end

        // 1: LOAD_LAT=1 classic single bubble: lw $2 in EX, add $3,$2,$4 in ID
        do_reset();
        drive(1'b1, 1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("t1_stall", 32'(stall[1]), 32'd1);
        check("t1_pcw", 32'(pcw[1]), 32'd0);
        check("t1_ifw", 32'(ifw[1]), 32'd0);
        check("t1_bub", 32'(bub[1]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("t1_after_stall", 32'(stall[1]), 32'd0);
        check("t1_after_pcw", 32'(pcw[1]), 32'd1);
        check("t1_after_bub", 32'(bub[1]), 32'd0);
        check("t1_l3_trk", 32'(stall[3]), 32'd1);

        // 2: LOAD_LAT=3, lw $5 then sw $5 directly behind: 3 stalls
        do_reset();
        drive(1'b1, 1'b1, 5'd5, 5'd29, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("t2_c0", 32'(stall[3]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd29, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("t2_c1", 32'(stall[3]), 32'd1);
        tick();
        #2;
        check("t2_c2", 32'(stall[3]), 32'd1);
        tick();
        #2;
        check("t2_c3", 32'(stall[3]), 32'd0);
        check("t2_c3_pcw", 32'(pcw[3]), 32'd1);

        // 2b: one independent op between load and consumer: 2 stalls
        do_reset();
        drive(1'b1, 1'b1, 5'd5, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        check("t2b_c0", 32'(stall[3]), 32'd0);
        tick();
        drive(1'b1, 1'b0, 5'd8, 5'd29, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("t2b_c1", 32'(stall[3]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd29, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("t2b_c2", 32'(stall[3]), 32'd1);
        tick();
        #2;
        check("t2b_c3", 32'(stall[3]), 32'd0);

        // 3: lw $0 never hazards; unused rt never hazards
        do_reset();
        drive(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        check("t3_zero_l1", 32'(stall[1]), 32'd0);
        check("t3_zero_l4", 32'(stall[4]), 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        check("t3_zero_trk_l4", 32'(stall[4]), 32'd0);
        tick();
        drive(1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        check("t3_rt_unused", 32'(stall[1]), 32'd0);
        drive(1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        check("t3_rt_used", 32'(stall[1]), 32'd1);

        // 4: flush wins over hazard; squashed load never enters tracker
        do_reset();
        drive(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        check("t4_stall", 32'(stall[2]), 32'd0);
        check("t4_bub", 32'(bub[2]), 32'd1);
        check("t4_pcw", 32'(pcw[2]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t4_no_trk", 32'(stall[2]), 32'd0);

        // 5: LOAD_LAT=2 with mem_wait for 3 cycles mid-stall
        do_reset();
        drive(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t5_c0", 32'(stall[2]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_wait%0d_stall", i), 32'(stall[2]), 32'd0);
            check($sformatf("t5_wait%0d_pcw", i), 32'(pcw[2]), 32'd0);
            check($sformatf("t5_wait%0d_bub", i), 32'(bub[2]), 32'd0);
            tick();
            #2;
        end
        drive(1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t5_resume", 32'(stall[2]), 32'd1);
        check("t5_resume_bub", 32'(bub[2]), 32'd1);
        tick();
        #2;
        check("t5_done", 32'(stall[2]), 32'd0);

        // 6: LOAD_LAT=4, count stalls, then reset mid-stall
        do_reset();
        drive(1'b1, 1'b1, 5'd11, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t6_c0", 32'(stall[4]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("t6_c%0d", i), 32'(stall[4]), 32'd1);
            tick();
            #2;
        end
        check("t6_c4", 32'(stall[4]), 32'd0);
        check("t6_cnt4", 32'(cnt[4]), Stats ? 32'd4 : 32'd0);
        tick();
        drive(1'b1, 1'b1, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t6_c5", 32'(stall[4]), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("t6_c6", 32'(stall[4]), 32'd1);
        check("t6_cnt5", 32'(cnt[4]), Stats ? 32'd5 : 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_stall", 32'(stall[4]), 32'd0);
        check("t6_rst_pcw", 32'(pcw[4]), 32'd1);
        check("t6_rst_cnt", 32'(cnt[4]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #2;
        check("t6_post_rst", 32'(stall[4]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
